iob_axi_ram_slave: RTL
======================

Name: iob_axi_ram_slave

Overview:
- AXI4 slave memory responder: the far end of the system's AXI master (external-memory) port.
- Serves INCR bursts from an internal dual-port synchronous RAM.
- Replaces the DDR4 controller and async bridge in simulation and on boards without external memory.
- Independent read and write FSMs, one outstanding transaction per direction.

Parameters:
AXI_ID_W, 4, ID width on all channels
AXI_LEN_W, 8, burst length field width
AXI_ADDR_W, 14, byte address width; RAM holds 2**(AXI_ADDR_W-log2(AXI_DATA_W/8)) words
AXI_DATA_W, 32, data width (32 or 64)

Ports:
clk_i  in  1  system clock
arst_i  in  1  asynchronous reset, active high
axi_awid_i  in  AXI_ID_W  write ID
axi_awaddr_i  in  AXI_ADDR_W  write start byte address
axi_awlen_i  in  AXI_LEN_W  write beats minus 1
axi_awvalid_i  in  1  AW valid
axi_awready_o  out  1  AW ready
axi_wdata_i  in  AXI_DATA_W  write data
axi_wstrb_i  in  AXI_DATA_W/8  byte enables
axi_wlast_i  in  1  last write beat
axi_wvalid_i  in  1  W valid
axi_wready_o  out  1  W ready
axi_bid_o  out  AXI_ID_W  response ID
axi_bresp_o  out  2  write response
axi_bvalid_o  out  1  B valid
axi_bready_i  in  1  B ready
axi_arid_i  in  AXI_ID_W  read ID
axi_araddr_i  in  AXI_ADDR_W  read start byte address
axi_arlen_i  in  AXI_LEN_W  read beats minus 1
axi_arvalid_i  in  1  AR valid
axi_arready_o  out  1  AR ready
axi_rid_o  out  AXI_ID_W  read ID
axi_rdata_o  out  AXI_DATA_W  read data
axi_rresp_o  out  2  read response, always 2'b00
axi_rlast_o  out  1  last read beat
axi_rvalid_o  out  1  R valid
axi_rready_i  in  1  R ready

Behaviour:
- Reset (arst_i high, async):
  - All outputs 0; both FSMs return to idle and any in-flight burst is abandoned.
  - RAM contents are not cleared.
  - awready/arready are registered and rise on the first clk_i edge after reset release.
- Bursts: full-width beats and INCR only; SIZE/BURST/LOCK/CACHE/PROT/QOS are not ported.
- Addressing: word address = addr[AXI_ADDR_W-1:log2(AXI_DATA_W/8)]; low bits ignored; increments by 1 per beat and wraps modulo depth.
- Write FSM:
  - W_IDLE: awready=1. AW handshake latches id, word address and len, then clears the beat count -> W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes whose wstrb bit is set, increments address and count. The beat where count==len -> W_RESP.
  - W_DATA error rule: wlast asserted on any other beat, or deasserted on the final beat, sets the error flag. Data is still written and the burst still ends on count==len.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 if error flag else 2'b00. Held until bready -> W_IDLE, with awready=1 the next cycle.
- Read FSM:
  - R_IDLE: arready=1. AR handshake at cycle N latches id and len and issues the RAM read of the start address -> R_DATA. rvalid=1 at N+1.
  - R_DATA: rdata comes straight from the RAM output register. On rvalid&rready with beats remaining, the next address is read in the same cycle, so rvalid stays high: one beat per cycle, no bubbles.
  - R_DATA backpressure: rready=0 holds the RAM enable low, so rdata, rlast and rvalid stay stable.
  - rlast=1 when beat index==len. Handshake of the rlast beat -> R_IDLE, rvalid=0, arready=1 next cycle.
- Concurrency:
  - Read and write run concurrently.
  - Same word read and written in the same cycle returns old data (read-first).
  - A read issued after a write's B handshake sees the new data.
- len=0 bursts are legal: one beat, rlast=1 on it; the W beat must carry wlast=1.

Test Plan:
- Reset: arst_i high mid-read-burst -> all outputs 0 immediately; after release, arready=1 next edge; RAM word previously written 0xDEADBEEF still reads 0xDEADBEEF.
- Write then read: AW addr 0x100 len 3, W data 0x11..0x44 with wstrb 0xF -> bresp 00, bid=AWID; AR 0x100 len 3 with rready=1 -> rvalid at N+1, four consecutive beats 0x11,0x22,0x33,0x44, rlast on the 4th only, rid=ARID.
- Strobes: write 0xAABBCCDD at 0x20, then 0x11223344 with wstrb 0x5 -> read returns 0xAA22CC44.
- Backpressure: read len 7 with rready toggling 1,0,0,1... -> no beat lost or duplicated, rdata stable while rready=0, eight beats total.
- Errors and wrap: early wlast on beat 1 of len 3 -> four beats written, bresp 2'b10. Burst of len 3 at the last-but-one word wraps to words 0 and 1.
- Concurrency: simultaneous AW/AR to the same address -> both accepted the same cycle; read returns pre-write data; the following read returns new data.

Source files
------------

// File: rtl/iob_axi_ram_slave.sv
// AXI4 slave memory responder: INCR bursts served from an internal
// dual-port synchronous RAM, with independent read and write FSMs.
// Ports:
//   clk_i, arst_i               clock and async active-high reset
//   axi_aw*/axi_w*/axi_b*       write address, data and response channels
//   axi_ar*/axi_r*              read address and data channels
module iob_axi_ram_slave #(
  parameter int AXI_ID_W   = 4,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ADDR_W = 14,
  parameter int AXI_DATA_W = 32
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [AXI_ID_W-1:0]     axi_awid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  input  logic [AXI_ID_W-1:0]     axi_arid_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i
);

  localparam int STRB_W = AXI_DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int WA_W   = AXI_ADDR_W - OFF_W;
  localparam int DEPTH  = 1 << WA_W;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  w_state_t             w_state;
  logic [WA_W-1:0]      w_addr;
  logic [AXI_LEN_W-1:0] w_len;
  logic [AXI_LEN_W-1:0] w_cnt;
  logic                 w_err;
  logic                 w_fire;
  logic                 w_final;
  logic                 w_bad;
  logic [WA_W-1:0]      aw_word;

  r_state_t             r_state;
  logic [WA_W-1:0]      r_addr;
  logic [AXI_LEN_W-1:0] r_len;
  logic [AXI_LEN_W-1:0] r_beat;
  logic [AXI_LEN_W-1:0] r_beat_nx;
  logic                 ar_fire;
  logic                 r_fire;
  logic                 ram_ren;
  logic [WA_W-1:0]      ram_raddr;
  logic [WA_W-1:0]      ar_word;

  assign aw_word = WA_W'(axi_awaddr_i >> OFF_W);
  assign ar_word = WA_W'(axi_araddr_i >> OFF_W);

  assign w_fire  = (w_state == W_DATA) &
                   axi_wready_o & axi_wvalid_i;
  assign w_final = (w_cnt == w_len);
  // wlast must be high exactly on the final beat
  assign w_bad   = axi_wlast_i ^ w_final;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      w_state       <= W_IDLE;
      axi_awready_o <= 1'b0;
      axi_wready_o  <= 1'b0;
      axi_bvalid_o  <= 1'b0;
      axi_bresp_o   <= 2'b00;
      axi_bid_o     <= '0;
      w_addr        <= '0;
      w_len         <= '0;
      w_cnt         <= '0;
      w_err         <= 1'b0;
    end else begin
      unique case (w_state)
        W_IDLE: begin
          if (axi_awready_o && axi_awvalid_i) begin
            axi_bid_o     <= axi_awid_i;
            w_addr        <= aw_word;
            w_len         <= axi_awlen_i;
            w_cnt         <= '0;
            w_err         <= 1'b0;
            axi_awready_o <= 1'b0;
            axi_wready_o  <= 1'b1;
            w_state       <= W_DATA;
          end else begin
            axi_awready_o <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_addr <= w_addr + 1'b1;
            w_cnt  <= w_cnt + 1'b1;
            w_err  <= w_err | w_bad;
            if (w_final) begin
              axi_wready_o <= 1'b0;
              axi_bvalid_o <= 1'b1;
              axi_bresp_o  <= (w_err | w_bad) ?
                              2'b10 : 2'b00;
              w_state      <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi_bready_i) begin
            axi_bvalid_o  <= 1'b0;
            axi_bresp_o   <= 2'b00;
            axi_awready_o <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_fire) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (axi_wstrb_i[b]) begin
          mem[w_addr][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign ar_fire   = (r_state == R_IDLE) &
                     axi_arready_o & axi_arvalid_i;
  assign r_fire    = axi_rvalid_o & axi_rready_i;
  assign r_beat_nx = r_beat + 1'b1;

  // RAM enable follows the handshake, so a stalled beat keeps rdata
  always_comb begin
    ram_ren   = 1'b0;
    ram_raddr = r_addr;
    if (ar_fire) begin
      ram_ren   = 1'b1;
      ram_raddr = ar_word;
    end else if ((r_state == R_DATA) && r_fire &&
                 !axi_rlast_o) begin
      ram_ren = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      axi_rdata_o <= '0;
    end else if (ram_ren) begin
      axi_rdata_o <= mem[ram_raddr];
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state       <= R_IDLE;
      axi_arready_o <= 1'b0;
      axi_rvalid_o  <= 1'b0;
      axi_rlast_o   <= 1'b0;
      axi_rid_o     <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (ar_fire) begin
            axi_rid_o     <= axi_arid_i;
            r_len         <= axi_arlen_i;
            r_beat        <= '0;
            r_addr        <= ar_word + 1'b1;
            axi_rvalid_o  <= 1'b1;
            axi_rlast_o   <= (axi_arlen_i == '0);
            axi_arready_o <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            axi_arready_o <= 1'b1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (axi_rlast_o) begin
              axi_rvalid_o  <= 1'b0;
              axi_rlast_o   <= 1'b0;
              axi_arready_o <= 1'b1;
              r_state       <= R_IDLE;
            end else begin
              r_beat      <= r_beat_nx;
              r_addr      <= r_addr + 1'b1;
              axi_rlast_o <= (r_beat_nx == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign axi_rresp_o = 2'b00;

endmodule
